// File: rtl/jk_bank_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : jk_bank_sequencer_if                                             |
// | Brief    : Command handshake and status bundle for the J-K bank sequencer.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmdValid;
  logic             cmdReady;
  logic [2:0]       cmdOp;
  logic [WIDTH-1:0] cmdData;
  logic [CNT_W-1:0] cmdCount;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output cmdValid, cmdOp, cmdData, cmdCount, abort,
    input  cmdReady, busy, done, aborted
  );

  modport slave (
    input  cmdValid, cmdOp, cmdData, cmdCount, abort,
    output cmdReady, busy, done, aborted
  );
endinterface
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : jk_bank_sequencer                                                |
// | Brief    : Drives J/K lines of an external flop bank to set, load, count    |
// |            and shift it, one handshaked command at a time.                  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             asyncReset,
  jk_bank_sequencer_if.slave cmd,
  input  logic [WIDTH-1:0] qIn,
  output logic [WIDTH-1:0] jOut,
  output logic [WIDTH-1:0] kOut
);

  localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(WIDTH - 1);

  localparam logic [2:0] c_OP_SET    = 3'd1;
  localparam logic [2:0] c_OP_CLEAR  = 3'd2;
  localparam logic [2:0] c_OP_TOGGLE = 3'd3;
  localparam logic [2:0] c_OP_LOAD   = 3'd4;
  localparam logic [2:0] c_OP_COUNT  = 3'd5;
  localparam logic [2:0] c_OP_SHIFT  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state,    w_stateNext;
  logic [2:0]         r_op,       w_opNext;
  logic [WIDTH-1:0]   r_data,     w_dataNext;
  logic [CNT_W-1:0]   r_lastStep, w_lastStepNext;
  logic [CNT_W-1:0]   r_step,     w_stepNext;
  logic [c_IDX_W-1:0] r_bitIdx,   w_bitIdxNext;
  logic               r_aborted,  w_abortedNext;

  logic [WIDTH-1:0]   w_opJ;
  logic [WIDTH-1:0]   w_opK;
  logic               w_carry;
  logic               w_shiftIn;
  logic               w_isMulti;

  always_ff @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_data     <= '0;
      r_lastStep <= '0;
      r_step     <= '0;
      r_bitIdx   <= '0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_op       <= w_opNext;
      r_data     <= w_dataNext;
      r_lastStep <= w_lastStepNext;
      r_step     <= w_stepNext;
      r_bitIdx   <= w_bitIdxNext;
      r_aborted  <= w_abortedNext;
    end
  end

  // Per-op J/K pattern; gated by state and abort further down.
  always_comb begin
    w_opJ     = '0;
    w_opK     = '0;
    w_carry   = 1'b1;
    w_shiftIn = r_data[r_bitIdx];
    case (r_op)
      c_OP_SET:    w_opJ = r_data;
      c_OP_CLEAR:  w_opK = r_data;
      c_OP_TOGGLE: begin
        w_opJ = r_data;
        w_opK = r_data;
      end
      c_OP_LOAD: begin
        w_opJ = r_data;
        w_opK = ~r_data;
      end
      c_OP_COUNT: begin
        for (int i = 0; i < WIDTH; i++) begin
          w_opJ[i] = w_carry;
          w_opK[i] = w_carry;
          w_carry  = w_carry & qIn[i];
        end
      end
      c_OP_SHIFT: begin
        w_opJ[0]         = w_shiftIn;
        w_opK[0]         = ~w_shiftIn;
        w_opJ[WIDTH-1:1] = qIn[WIDTH-2:0];
        w_opK[WIDTH-1:1] = ~qIn[WIDTH-2:0];
      end
      default: ;
    endcase
  end

  assign w_isMulti = (cmd.cmdOp == c_OP_COUNT) || (cmd.cmdOp == c_OP_SHIFT);

  always_comb begin
    w_stateNext    = r_state;
    w_opNext       = r_op;
    w_dataNext     = r_data;
    w_lastStepNext = r_lastStep;
    w_stepNext     = r_step;
    w_bitIdxNext   = r_bitIdx;
    w_abortedNext  = r_aborted;
    jOut           = '0;
    kOut           = '0;
    cmd.cmdReady   = 1'b0;
    cmd.busy       = 1'b0;
    cmd.done       = 1'b0;
    cmd.aborted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd.cmdReady = 1'b1;
        if (cmd.cmdValid) begin
          w_opNext      = cmd.cmdOp;
          w_dataNext    = cmd.cmdData;
          w_stepNext    = '0;
          w_bitIdxNext  = '0;
          w_abortedNext = 1'b0;
          // Stored as the index of the final step so a count of 0 runs once.
          w_lastStepNext = (w_isMulti && (cmd.cmdCount != '0))
                         ? cmd.cmdCount - CNT_W'(1) : '0;
          w_stateNext   = S_APPLY;
        end
      end
      S_APPLY: begin
        cmd.busy     = 1'b1;
        w_stepNext   = r_step + CNT_W'(1);
        w_bitIdxNext = (r_bitIdx == c_LAST_BIT) ? '0 : r_bitIdx + c_IDX_W'(1);
        if (cmd.abort) begin
          w_abortedNext = 1'b1;
          w_stateNext   = S_DONE;
        end else begin
          jOut = w_opJ;
          kOut = w_opK;
          if (r_step == r_lastStep) begin
            w_stateNext = S_DONE;
          end
        end
      end
      S_DONE: begin
        cmd.done    = 1'b1;
        cmd.aborted = r_aborted;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_jk_bank_sequencer                                             |
// | Brief    : Self-checking bench with a J-K flop bank model and scoreboard.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_jk_bank_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  localparam logic [2:0] NOP = 3'd0, SET = 3'd1, CLR = 3'd2, TGL = 3'd3;
  localparam logic [2:0] LOAD = 3'd4, COUNT = 3'd5, SHIFT = 3'd6, RSV = 3'd7;

  logic             clk = 1'b0;
  logic             asyncReset = 1'b0;
  logic [WIDTH-1:0] qIn;
  logic [WIDTH-1:0] jOut;
  logic [WIDTH-1:0] kOut;

  jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .asyncReset (asyncReset),
    .cmd        (cmd),
    .qIn        (qIn),
    .jOut       (jOut),
    .kOut       (kOut)
  );

  always #5 clk = ~clk;

  // External bank of jkff_async_reset flops.
  always @(posedge clk or negedge asyncReset) begin
    if (!asyncReset) qIn <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({jOut[i], kOut[i]})
          2'b01:   qIn[i] <= 1'b0;
          2'b10:   qIn[i] <= 1'b1;
          2'b11:   qIn[i] <= ~qIn[i];
          default: ;
        endcase
      end
    end
  end

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             ab;
    int               nBusy;
  } sb_t;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] expQ;
    int               expN;
  } vec_t;

  sb_t              sbQ[$];
  logic [WIDTH-1:0] traceQ[$];
  vec_t             vecs[14];
  int               checks = 0;
  int               failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts at edge+1 in IDLE; returns at edge+1 back in IDLE.
  task automatic runCmd(input logic [2:0] op, input logic [WIDTH-1:0] data,
                        input logic [CNT_W-1:0] count, input logic [WIDTH-1:0] expQ,
                        input int expN, input int abortAt, input string name);
    sb_t e;
    int  busyCnt;
    bit  seen;
    bit  prevApply;
    e.q = expQ; e.ab = (abortAt != 0); e.nBusy = expN;
    check({name, ":ready"}, cmd.cmdReady, 1);
    cmd.cmdValid = 1'b1; cmd.cmdOp = op; cmd.cmdData = data; cmd.cmdCount = count;
    sbQ.push_back(e);
    @(posedge clk); #1;
    cmd.cmdValid = 1'b0; cmd.cmdOp = op ^ 3'b101; cmd.cmdData = ~data; cmd.cmdCount = count + 8'd7;
    busyCnt = 0; seen = 0; prevApply = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      if (prevApply && traceQ.size() > 0) check({name, ":step"}, qIn, traceQ.pop_front());
      prevApply = 0;
      if (cmd.done) begin
        seen = 1;
        e = sbQ.pop_front();
        check({name, ":q"}, qIn, e.q);
        check({name, ":aborted"}, cmd.aborted, e.ab);
        check({name, ":busyCycles"}, busyCnt, e.nBusy);
        check({name, ":doneJK"}, {jOut, kOut}, 0);
        check({name, ":doneBusy"}, cmd.busy, 0);
      end else begin
        if (cmd.busy) begin
          busyCnt++;
          cmd.abort = (busyCnt == abortAt);
          #1;
          if (cmd.abort) check({name, ":abortJK"}, {jOut, kOut}, 0);
          else if (busyCnt == 1 && op == LOAD) check({name, ":loadJK"}, {jOut, kOut}, {data, ~data});
          prevApply = !cmd.abort;
        end
        @(posedge clk); #1;
        cmd.abort = 1'b0;
      end
    end
    check({name, ":doneSeen"}, seen, 1);
    if (!seen) begin
      sbQ.delete();
      traceQ.delete();
    end
    @(posedge clk); #1;
    check({name, ":donePulse"}, cmd.done, 0);
    check({name, ":readyAfter"}, cmd.cmdReady, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneCnt;
    cmd.cmdValid = 1'b0; cmd.cmdOp = '0; cmd.cmdData = '0; cmd.cmdCount = '0; cmd.abort = 1'b0;

    vecs[0]  = '{LOAD,  4'b1010, 8'd0, 4'b1010, 1};
    vecs[1]  = '{LOAD,  4'b0110, 8'd0, 4'b0110, 1};
    vecs[2]  = '{TGL,   4'b0011, 8'd0, 4'b0101, 1};
    vecs[3]  = '{SET,   4'b1000, 8'd0, 4'b1101, 1};
    vecs[4]  = '{CLR,   4'b0101, 8'd0, 4'b1000, 1};
    vecs[5]  = '{NOP,   4'b1111, 8'd0, 4'b1000, 1};
    vecs[6]  = '{RSV,   4'b1111, 8'd9, 4'b1000, 1};
    vecs[7]  = '{SET,   4'b0001, 8'd5, 4'b1001, 1};
    vecs[8]  = '{LOAD,  4'b1111, 8'd0, 4'b1111, 1};
    vecs[9]  = '{COUNT, 4'b0000, 8'd0, 4'b0000, 1};
    vecs[10] = '{COUNT, 4'b0000, 8'd2, 4'b0010, 2};
    vecs[11] = '{LOAD,  4'b0011, 8'd0, 4'b0011, 1};
    vecs[12] = '{SHIFT, 4'b0001, 8'd1, 4'b0111, 1};
    vecs[13] = '{SHIFT, 4'b0000, 8'd0, 4'b1110, 1};

    #3;
    check("rst:ready", cmd.cmdReady, 1);
    check("rst:busy", cmd.busy, 0);
    check("rst:done", cmd.done, 0);
    check("rst:aborted", cmd.aborted, 0);
    check("rst:jk", {jOut, kOut}, 0);
    check("rst:q", qIn, 0);
    #19 asyncReset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      runCmd(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].expQ, vecs[i].expN, 0,
             $sformatf("vec%0d", i));

    runCmd(LOAD, 4'b1110, 8'd0, 4'b1110, 1, 0, "ld1110");
    traceQ = '{4'b1111, 4'b0000, 4'b0001};
    runCmd(COUNT, 4'b0000, 8'd3, 4'b0001, 3, 0, "count3");

    runCmd(LOAD, 4'b0000, 8'd0, 4'b0000, 1, 0, "ld0a");
    traceQ = '{4'b0001, 4'b0010, 4'b0101, 4'b1010};
    runCmd(SHIFT, 4'b0101, 8'd4, 4'b1010, 4, 0, "shift4");

    runCmd(LOAD, 4'b0000, 8'd0, 4'b0000, 1, 0, "ld0b");
    traceQ = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0101, 4'b1010};
    runCmd(SHIFT, 4'b0101, 8'd6, 4'b1010, 6, 0, "shift6");

    runCmd(LOAD, 4'b0000, 8'd0, 4'b0000, 1, 0, "ld0c");
    traceQ = '{4'b0001, 4'b0010, 4'b0011};
    runCmd(COUNT, 4'b0000, 8'd10, 4'b0011, 4, 4, "abort4");

    runCmd(LOAD, 4'b0000, 8'd0, 4'b0000, 1, 0, "ld0d");
    traceQ = '{4'b0001};
    runCmd(COUNT, 4'b0000, 8'd2, 4'b0001, 2, 2, "abortLast");

    // Abort while idle must not start or finish anything.
    cmd.abort = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idleAbort:done", cmd.done, 0);
    check("idleAbort:busy", cmd.busy, 0);
    check("idleAbort:ready", cmd.cmdReady, 1);
    cmd.abort = 1'b0;

    // Reset in the middle of a long COUNT.
    cmd.cmdValid = 1'b1; cmd.cmdOp = COUNT; cmd.cmdData = '0; cmd.cmdCount = 8'd200;
    @(posedge clk); #1;
    cmd.cmdValid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midRst:busyBefore", cmd.busy, 1);
    asyncReset = 1'b0;
    #1;
    check("midRst:jk", {jOut, kOut}, 0);
    check("midRst:busy", cmd.busy, 0);
    check("midRst:done", cmd.done, 0);
    check("midRst:ready", cmd.cmdReady, 1);
    check("midRst:q", qIn, 0);
    doneCnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (cmd.done) doneCnt++;
    end
    #2 asyncReset = 1'b1;
    @(posedge clk); #1;
    if (cmd.done) doneCnt++;
    check("midRst:noDone", doneCnt, 0);
    runCmd(LOAD, 4'b1010, 8'd0, 4'b1010, 1, 0, "postRst");

    check("sb:empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
